// File: rtl/fifo_buffer.sv
// Parametrised first-word-fall-through FIFO with valid/ready handshakes on both sides.
// in_ready, out_valid, out_data, count and almost_full depend on registered state only.
module fifo_buffer #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    assign in_ready    = (count_q != FULL_CNT);
    assign out_valid   = (count_q != '0);
    assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count       = count_q;
    assign almost_full = (count_q >= AF_CNT);

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap explicitly so non-power-of-two depths work.
            if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally left out of reset and clear.
    always_ff @(posedge clock) begin
        if (push && !clear) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: doc/fifo_buffer.md
Name: fifo_buffer

Overview:
Parametrised synchronous first-in first-out (FIFO) buffer. It generalises the single-entry en/clear register into a DEPTH-entry queue with valid/ready handshakes on both sides. It decouples producer and consumer pipeline stages running on a single clock domain. The read side is first-word-fall-through: the head entry is presented on out_data whenever out_valid=1.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, number of storage entries (>=2, need not be a power of two)
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous flush; empties the FIFO on the next clock edge
in_data  input  WIDTH  write data
in_valid  input  1  producer has data on in_data
in_ready  output  1  FIFO can accept a word (= not full)
out_data  output  WIDTH  head-of-queue data
out_valid  output  1  FIFO holds at least one word (= not empty)
out_ready  input  1  consumer takes the head word
count  output  $clog2(DEPTH+1)  number of words currently stored
almost_full  output  1  count >= AF_LEVEL

Behaviour:
- Storage is DEPTH x WIDTH entries, plus a write pointer, read pointer and count register. Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 (explicit compare, not natural overflow).
- push = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated at the same rising edge.
- in_ready = (count != DEPTH); out_valid = (count != 0). Both are combinational from count only.
  - No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- push alone: write mem[wr_ptr] <= in_data, advance wr_ptr, count+1.
- pop alone: advance rd_ptr, count-1.
- push and pop in the same cycle: both pointers advance and count is unchanged. This is legal at any count from 1 to DEPTH-1.
  - When full, in_ready=0, so only the pop occurs; there is no write-through-on-full.
  - When empty, out_valid=0, so only the push occurs; there is no bypass.
- Latency: a word pushed at edge N is visible on out_data with out_valid=1 after edge N, i.e. in cycle N+1. The minimum fall-through is one cycle.
- out_data = mem[rd_ptr] when out_valid=1. It is forced to 0 when empty, so the output is deterministic.
- almost_full is a combinational compare of count against AF_LEVEL.
- clear (synchronous) sets wr_ptr, rd_ptr and count to 0 at the next edge.
  - clear has priority over a push or pop in the same cycle; that push and pop are discarded.
  - Memory contents are not cleared.
- reset (asynchronous) immediately drives wr_ptr=0, rd_ptr=0, count=0. The resulting output values during and after reset are:
  - in_ready=1, out_valid=0, out_data=0, count=0;
  - almost_full=0 (guaranteed because AF_LEVEL>=1).
  - Memory is not reset.
- Reset asserted mid-transfer discards all stored data. The first edge after reset deassertion behaves as the empty state.
- Handshake rules for neighbours:
  - The producer must hold in_data stable while in_valid=1 and in_ready=0.
  - The FIFO holds out_data stable while out_valid=1 and out_ready=0.
- Never overflow or underflow. An in_valid while full and an out_ready while empty are both ignored with no state change.

Test Plan:
- Reset, then idle with WIDTH=8, DEPTH=4 -> in_ready=1, out_valid=0, out_data=0, count=0, almost_full=0; assert reset asynchronously between edges and confirm the outputs change before the next edge.
- Push 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready=0 -> count steps 1,2,3,4; almost_full rises when count=3; in_ready=0 at count=4; a fifth push of 0x55 is ignored and count stays 4.
- From full, hold out_ready=1 for 4 cycles -> out_data reads 0x11,0x22,0x33,0x44 in order; out_valid=0 and out_data=0 afterwards; an extra out_ready is ignored and count stays 0.
- Simultaneous push/pop: hold count=2, then stream 20 incrementing words with in_valid=out_ready=1 -> count stays 2 throughout, pointers wrap several times, and the output sequence equals the input sequence delayed by 2 words.
- Single word into the empty FIFO: push 0xA5 at edge N -> out_valid=1 and out_data=0xA5 in cycle N+1, not earlier.
- Clear with count=3, asserted together with a push and a pop -> count=0, out_valid=0 and in_ready=1 after the edge; a subsequent push of 0x7E then appears as the head word 0x7E, not stale data.
